// File: rtl/sequence_player.sv
// sequence_player: stores a growing pseudo-random colour sequence and
// replays it through four LED display stages using an enable/done-flag handshake.
//
// Ports:
//   clk, rst_n  clock (rising edge) and async active-low reset
//   start       pulse, replay the stored sequence (IDLE only)
//   append      pulse, add one random step (IDLE only, wins over start)
//   led_done    per-colour done flags from the display stages
//   led_en      one-hot stage enables, zero while dark
//   seq_len     number of stored steps
//   step_idx    index of the step being shown, 0 when idle
//   busy        high from accepted start until the done pulse
//   done        one-cycle pulse when playback completes
//   full        seq_len == MAX_LEN
//   timeout     one-cycle pulse on a stuck stage (SEQ_PLAYER_TIMEOUT_EN only)
//
// Optional feature: define SEQ_PLAYER_TIMEOUT_EN to add the stage watchdog.

module sequence_player #(
   parameter int          MAX_LEN     = 16,
   parameter int          GAP_CYCLES  = 1000,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
`ifdef SEQ_PLAYER_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_CYC = 20000
`endif
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         append,
   input  logic [3:0]                   led_done,
   output logic [3:0]                   led_en,
   output logic [$clog2(MAX_LEN+1)-1:0] seq_len,
   output logic [$clog2(MAX_LEN)-1:0]   step_idx,
   output logic                         busy,
   output logic                         done,
   output logic                         full
`ifdef SEQ_PLAYER_TIMEOUT_EN
   ,
   output logic                         timeout
`endif
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int IW = $clog2(MAX_LEN);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHOW,
      S_RELEASE,
      S_GAP,
      S_FINISH
   } state_t;

   state_t          r_state;
   logic [15:0]     r_lfsr;
   logic [1:0]      r_mem [MAX_LEN];
   logic [3:0]      r_led_en;
   logic [LW-1:0]   r_seq_len;
   logic [IW-1:0]   r_step_idx;
   logic [GW-1:0]   r_gap;
   logic            r_busy;
   logic            r_done;

   logic            w_fb;
   logic            w_full;
   logic            w_last;
   logic            w_add;
   logic [IW-1:0]   w_next_idx;
   logic [1:0]      w_col;
   logic [1:0]      w_next_col;

   assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_full     = (r_seq_len == LW'(MAX_LEN));
   assign w_next_idx = r_step_idx + IW'(1);
   assign w_last     = ((LW'(r_step_idx) + LW'(1)) == r_seq_len);
   assign w_add      = (r_state == S_IDLE) && append && !w_full;
   assign w_col      = r_mem[r_step_idx];
   assign w_next_col = r_mem[w_next_idx];

`ifdef SEQ_PLAYER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_timeout;
   assign timeout = r_timeout;
`endif

   // Sequence storage deliberately survives reset.
   always_ff @(posedge clk) begin
      if (w_add) begin
         r_mem[r_seq_len[IW-1:0]] <= r_lfsr[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_lfsr     <= LFSR_SEED;
         r_led_en   <= 4'b0;
         r_seq_len  <= '0;
         r_step_idx <= '0;
         r_gap      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef SEQ_PLAYER_TIMEOUT_EN
         r_to_cnt   <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
         // Free-running so the drawn colour depends on press timing.
         r_lfsr <= {r_lfsr[14:0], w_fb};
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (append) begin
                  if (!w_full) begin
                     r_seq_len <= r_seq_len + LW'(1);
                  end
               end else if (start) begin
                  if (r_seq_len == '0) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_step_idx <= '0;
                     r_busy     <= 1'b1;
                     r_state    <= S_SHOW;
                  end
               end
            end
            S_SHOW: begin
               // Only an acknowledge to a raised enable counts.
               if (r_led_en != 4'b0 && led_done[w_col]) begin
                  r_led_en <= 4'b0;
                  r_state  <= S_RELEASE;
               end else begin
                  r_led_en <= 4'b0001 << w_col;
               end
            end
            S_RELEASE: begin
               if (!led_done[w_col]) begin
                  r_gap   <= GW'(GAP_CYCLES - 1);
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_gap != '0) begin
                  r_gap <= r_gap - GW'(1);
               end else if (w_last) begin
                  r_state <= S_FINISH;
               end else begin
                  // Next enable rises on the gap exit edge.
                  r_step_idx <= w_next_idx;
                  r_led_en   <= 4'b0001 << w_next_col;
                  r_state    <= S_SHOW;
               end
            end
            S_FINISH: begin
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_step_idx <= '0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
`ifdef SEQ_PLAYER_TIMEOUT_EN
         r_timeout <= 1'b0;
         if (r_state == S_SHOW || r_state == S_RELEASE) begin
            if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
               r_timeout  <= 1'b1;
               r_led_en   <= 4'b0;
               r_busy     <= 1'b0;
               r_step_idx <= '0;
               r_to_cnt   <= '0;
               r_state    <= S_IDLE;
            end else begin
               r_to_cnt <= r_to_cnt + TW'(1);
            end
         end else begin
            r_to_cnt <= '0;
         end
`endif
      end
   end

   assign led_en   = r_led_en;
   assign seq_len  = r_seq_len;
   assign step_idx = r_step_idx;
   assign busy     = r_busy;
   assign done     = r_done;
   assign full     = w_full;

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed bench for sequence_player with a
// display-stage model (flag 3 cycles after enable, cleared 1 cycle after drop).

module tb_sequence_player;

   localparam int MAX_LEN = 16;
   localparam int GAP     = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       append = 1'b0;
   logic [3:0] led_done;
   logic [3:0] led_en;
   logic [4:0] seq_len;
   logic [3:0] step_idx;
   logic       busy;
   logic       done;
   logic       full;
`ifdef SEQ_PLAYER_TIMEOUT_EN
   logic       timeout;
`endif

   int          n_chk = 0;
   int          n_fail = 0;
   int          m_len = 0;
   bit          model_en = 1'b1;
   logic [15:0] m_lfsr;
   logic [1:0]  exp_col [MAX_LEN];
   int          m_cnt [4];

   always #5 clk = ~clk;

   sequence_player #(
      .MAX_LEN    (MAX_LEN),
      .GAP_CYCLES (GAP)
`ifdef SEQ_PLAYER_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(50)
`endif
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .append   (append),
      .led_done (led_done),
      .led_en   (led_en),
      .seq_len  (seq_len),
      .step_idx (step_idx),
      .busy     (busy),
      .done     (done),
      .full     (full)
`ifdef SEQ_PLAYER_TIMEOUT_EN
      ,
      .timeout  (timeout)
`endif
   );

   // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift left.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else m_lfsr <= {m_lfsr[14:0],
                      m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   // Display stages.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_done <= 4'b0;
         for (int c = 0; c < 4; c++) m_cnt[c] <= 0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (model_en && led_en[c]) begin
               if (m_cnt[c] == 2) led_done[c] <= 1'b1;
               else m_cnt[c] <= m_cnt[c] + 1;
            end else begin
               m_cnt[c]    <= 0;
               led_done[c] <= 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_append(input bit with_start);
      if (m_len < MAX_LEN) begin
         exp_col[m_len] = m_lfsr[1:0];
         m_len++;
      end
      append = 1'b1;
      start  = with_start;
      tick();
      append = 1'b0;
      start  = 1'b0;
      check("seq_len", seq_len, m_len);
      check("full", full, m_len == MAX_LEN);
   endtask

   // Per step: lit 4 cycles; dark = 2 release cycles + GAP gap cycles.
   task automatic play(input int n, input bit inj);
      int w;
      int l;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_on", busy, 1);
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (led_en == 4'b0 && w < 100) begin
            w++;
            tick();
         end
         if (i == 0) check("latency", w, 1);
         else check("dark_gap", w, GAP + 2);
         check("led_en", led_en, 4'b0001 << exp_col[i]);
         check("step_idx", step_idx, i);
         check("busy", busy, 1);
         l = 0;
         while (led_en != 4'b0 && l < 100) begin
            l++;
            if (inj && i == 0 && l == 1) begin
               append = 1'b1;
               start  = 1'b1;
            end
            tick();
            append = 1'b0;
            start  = 1'b0;
         end
         check("lit_len", l, 4);
      end
      if (inj) check("busy_ignore", seq_len, m_len);
      w = 0;
      while (!done && w < 100) begin
         w++;
         tick();
      end
      check("done_wait", w, GAP + 3);
      check("done_hi", done, 1);
      check("busy_off", busy, 0);
      check("idx_zero", step_idx, 0);
      check("led_off", led_en, 0);
      tick();
      check("done_pulse", done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int w;
      bit seen;
      #7;
      check("rst_led_en", led_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_seq_len", seq_len, 0);
      check("rst_step_idx", step_idx, 0);
      check("rst_full", full, 0);
      #5 rst_n = 1'b1;
      tick();

      for (int k = 0; k < 3; k++) begin
         do_append(1'b0);
         repeat (4) tick();
      end
      play(3, 1'b0);

      while (m_len < MAX_LEN) do_append(1'b0);
      do_append(1'b0);
      check("full_hold", seq_len, 16);
      play(16, 1'b0);

      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (!(step_idx == 4'd2 && led_en != 4'b0) && w < 200) begin
         w++;
         tick();
      end
      check("reach_step2", step_idx, 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_led_en", led_en, 0);
      check("arst_seq_len", seq_len, 0);
      check("arst_busy", busy, 0);
      m_len = 0;
      #3 rst_n = 1'b1;
      tick();
      seen = 1'b0;
      repeat (20) begin
         seen |= done;
         tick();
      end
      check("no_done_rst", seen, 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      check("empty_busy", busy, 0);
      check("empty_done0", done, 0);
      tick();
      check("empty_done1", done, 1);
      check("empty_led", led_en, 0);
      tick();
      check("empty_done2", done, 0);

      do_append(1'b1);
      seen = 1'b0;
      repeat (15) begin
         seen |= (led_en != 4'b0) || busy || done;
         tick();
      end
      check("no_play", seen, 0);

      do_append(1'b0);
      repeat (2) tick();
      do_append(1'b0);
      play(3, 1'b1);

`ifdef SEQ_PLAYER_TIMEOUT_EN
      model_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      seen = 1'b0;
      while (!timeout && w < 200) begin
         w++;
         tick();
         seen |= done;
      end
      check("to_cycle", w, 50);
      check("to_led", led_en, 0);
      check("to_busy", busy, 0);
      check("to_no_done", seen, 0);
      tick();
      check("to_pulse", timeout, 0);
      check("to_done", done, 0);
      model_en = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
